// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer: state codes, RV32I major opcodes
// and the memory wait limit.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE: is_legal = 1'b1;
      default:                                           is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    writes_rd = !((opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_FENCE));
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait-state counter; clears on phase entry, counts stalled request cycles.
// expired is combinational: it marks the stalled cycle whose increment reaches WAIT_LIMIT.
module seq_wait_timer
  import cpu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (clr) begin
      r_cnt <= 8'd0;
    end else if (en && (r_cnt != WAIT_LIMIT)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = en && (r_cnt == (WAIT_LIMIT - 8'd1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/[MEM]/WB, 4 cycles (5 for ld/st)
// plus memory wait states; stalls on MEM_READY, traps on illegal opcode or wait timeout.
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] OPCODE,
  input  logic       MEM_READY,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_load,
  output logic       rd_we,
  output logic [2:0] state,
  output logic       illegal,
  output logic       bus_err
);

  state_t     r_state;
  state_t     w_nxt;
  logic [6:0] r_opcode;
  logic       r_illegal;
  logic       r_bus_err;
  logic       w_expired;
  logic       w_clr;
  logic       w_en;
  logic       w_is_mem;

  assign w_is_mem = (r_opcode == OPC_LOAD) || (r_opcode == OPC_STORE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_FETCH: begin
        if (MEM_READY)      w_nxt = ST_DECODE;
        else if (w_expired) w_nxt = ST_TRAP;
      end
      ST_DECODE: w_nxt = is_legal(OPCODE) ? ST_EXEC : ST_TRAP;
      ST_EXEC:   w_nxt = w_is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (MEM_READY)      w_nxt = ST_WB;
        else if (w_expired) w_nxt = ST_TRAP;
      end
      ST_WB:     w_nxt = ST_FETCH;
      ST_TRAP:   w_nxt = ST_TRAP;
      default:   w_nxt = ST_TRAP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_FETCH;
      r_opcode  <= 7'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_DECODE) r_opcode <= OPCODE;
      if ((r_state == ST_DECODE) && (w_nxt == ST_TRAP)) r_illegal <= 1'b1;
      if (((r_state == ST_FETCH) || (r_state == ST_MEM)) && (w_nxt == ST_TRAP))
        r_bus_err <= 1'b1;
    end
  end

  // Request strobes are gated by RST_N so an asserted reset drops them without a clock edge.
  assign mem_req  = RST_N && ((r_state == ST_FETCH) || (r_state == ST_MEM));
  assign mem_we   = RST_N && (r_state == ST_MEM) && (r_opcode == OPC_STORE);
  assign addr_sel = RST_N && (r_state == ST_MEM);
  assign ir_load  = RST_N && (r_state == ST_FETCH) && MEM_READY;
  assign pc_load  = RST_N && (r_state == ST_WB);
  assign rd_we    = RST_N && (r_state == ST_WB) && writes_rd(r_opcode);
  assign state    = r_state;
  assign illegal  = r_illegal;
  assign bus_err  = r_bus_err;

  assign w_clr = ((w_nxt == ST_FETCH) && (r_state != ST_FETCH)) ||
                 ((w_nxt == ST_MEM)   && (r_state != ST_MEM));
  assign w_en  = mem_req && !MEM_READY;

  seq_wait_timer u_wait (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (w_clr),
    .en      (w_en),
    .expired (w_expired)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: phase-list reference model, directed corner cases plus random instructions.
module tb_cpu_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] OPCODE;
  logic       MEM_READY;
  logic       mem_req, mem_we, addr_sel, ir_load, pc_load, rd_we, illegal, bus_err;
  logic [2:0] state;

  cpu_sequencer dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .OPCODE    (OPCODE),
    .MEM_READY (MEM_READY),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_load   (ir_load),
    .pc_load   (pc_load),
    .rd_we     (rd_we),
    .state     (state),
    .illegal   (illegal),
    .bus_err   (bus_err)
  );

  always #5 CLK = ~CLK;

  int n_err    = 0;
  int n_checks = 0;
  bit exp_ill  = 1'b0;
  bit exp_bus  = 1'b0;

  localparam logic [6:0] T_OP    = 7'b0110011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_ILL   = 7'b1110011;

  logic [6:0] legal_ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

  wire [10:0] obs = {state, mem_req, mem_we, addr_sel, ir_load, pc_load, rd_we, illegal, bus_err};

  function automatic bit op_legal(input logic [6:0] opc);
    bit hit = 1'b0;
    for (int i = 0; i < 10; i++) if (legal_ops[i] == opc) hit = 1'b1;
    return hit;
  endfunction

  function automatic bit op_mem(input logic [6:0] opc);
    return (opc == 7'b0000011) || (opc == 7'b0100011);
  endfunction

  function automatic bit op_no_rd(input logic [6:0] opc);
    return (opc == 7'b1100011) || (opc == 7'b0100011) || (opc == 7'b0001111);
  endfunction

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  // Phase numbers: 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback, 5 trap.
  function automatic logic [10:0] exp_vec(input int ph, input bit rdy, input logic [6:0] opc);
    logic [2:0] st = 3'(ph);
    bit req  = (ph == 0) || (ph == 3);
    bit we   = (ph == 3) && (opc == 7'b0100011);
    bit asel = (ph == 3);
    bit irl  = (ph == 0) && rdy;
    bit pcl  = (ph == 4);
    bit rdw  = (ph == 4) && !op_no_rd(opc);
    return {st, req, we, asel, irl, pcl, rdw, exp_ill, exp_bus};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Entered at a falling edge; returns at the next falling edge.
  task automatic do_cycle(input int ph, input bit rdy, input logic [6:0] drv,
                          input logic [6:0] insn, input string tag);
    MEM_READY = rdy;
    OPCODE    = drv;
    #1;
    check($sformatf("%s/ph%0d", tag, ph), obs, exp_vec(ph, rdy, insn));
    @(negedge CLK);
  endtask

  task automatic do_reset(input string tag);
    RST_N     = 1'b0;
    MEM_READY = 1'b0;
    #1;
    check({tag, "/in_reset"}, obs, 11'd0);
    @(negedge CLK);
    RST_N   = 1'b1;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
  endtask

  task automatic trap_tail(input logic [6:0] insn, input string tag);
    for (int i = 0; i < 20; i++) do_cycle(5, 1'($urandom), junk(), insn, tag);
  endtask

  task automatic wait_phase(input int ph, input int n, input logic [6:0] insn,
                            input string tag, output bit trapped);
    for (int i = 0; i < n && i < 255; i++) do_cycle(ph, 1'b0, junk(), insn, tag);
    if (n >= 255) begin
      exp_bus = 1'b1;
      trapped = 1'b1;
    end else begin
      do_cycle(ph, 1'b1, junk(), insn, tag);
      trapped = 1'b0;
    end
  endtask

  task automatic run_insn(input logic [6:0] opc, input int wf, input int wm, input string tag);
    bit trapped;
    wait_phase(0, wf, opc, tag, trapped);
    if (trapped) begin
      trap_tail(opc, tag);
      return;
    end
    do_cycle(1, 1'($urandom), opc, opc, tag);
    if (!op_legal(opc)) begin
      exp_ill = 1'b1;
      trap_tail(opc, tag);
      return;
    end
    do_cycle(2, 1'($urandom), junk(), opc, tag);
    if (op_mem(opc)) begin
      wait_phase(3, wm, opc, tag, trapped);
      if (trapped) begin
        trap_tail(opc, tag);
        return;
      end
    end
    do_cycle(4, 1'($urandom), junk(), opc, tag);
  endtask

  initial begin
    RST_N     = 1'b0;
    MEM_READY = 1'b0;
    OPCODE    = 7'd0;
    @(negedge CLK);
    do_reset("por");

    run_insn(T_OP, 0, 0, "alu");
    run_insn(T_LOAD, 0, 3, "load_w3");
    run_insn(T_STORE, 0, 0, "store");
    run_insn(T_LOAD, 2, 254, "mem_ready_255");

    for (int k = 0; k < 30; k++) begin
      run_insn(legal_ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
               $sformatf("rnd%0d", k));
    end

    run_insn(T_ILL, 0, 0, "illegal");
    do_reset("ill_clear");
    run_insn(T_OP, 0, 0, "after_ill");

    do_reset("pre_fto");
    run_insn(T_OP, 255, 0, "fetch_timeout");
    do_reset("fto_clear");
    run_insn(T_OP, 254, 0, "fetch_ready_255");

    run_insn(T_STORE, 1, 255, "mem_timeout");
    do_reset("mto_clear");

    run_insn(T_OP, 0, 0, "pre_midmem");
    do_cycle(0, 1'b1, junk(), T_STORE, "midmem");
    do_cycle(1, 1'b0, T_STORE, T_STORE, "midmem");
    do_cycle(2, 1'b0, junk(), T_STORE, "midmem");
    MEM_READY = 1'b0;
    #1;
    check("midmem/before_rst", obs, exp_vec(3, 1'b0, T_STORE));
    RST_N = 1'b0;
    #1;
    check("midmem/async_drop", obs, 11'd0);
    @(negedge CLK);
    do_reset("midmem_release");
    run_insn(T_STORE, 0, 0, "post_midmem");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
